// File: rtl/rng_window_stats.sv
// Purpose : windowed mean/min/max statistics over 2^WIN_LOG2 valid VT_RNG x samples.
// Latency : done pulses 1 cycle after the edge that accepts the final sample of a window.
// Backpressure: none; samples with i_x_valid=0 are skipped, and inputs outside ACC are ignored.
//
// Optional feature macro: RNG_STATS_REPEAT_EN (adds o_rep_cnt, the count of
// accepted samples equal to the previous accepted sample of the same window).
//
// Ports:
//   i_clk        : clock, all logic on the rising edge
//   i_reset      : synchronous active-high reset
//   i_start      : begin a new window (honoured only in IDLE)
//   i_x_in       : sample value
//   i_x_valid    : i_x_in carries a sample this cycle
//   o_busy       : high while accumulating (ACC)
//   o_done       : one-cycle pulse when results of a window are valid
//   o_mean       : floor(sum / 2^WIN_LOG2) of the last completed window
//   o_min_val    : smallest sample of the last completed window
//   o_max_val    : largest sample of the last completed window
//   o_sample_cnt : valid samples taken in the current/last window
//   o_rep_cnt    : repeat count of the last completed window (macro only)
module rng_window_stats #(
    parameter int DATA_W   = 18,
    parameter int WIN_LOG2 = 10
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [DATA_W-1:0]   i_x_in,
    input  logic                i_x_valid,
    output logic                o_busy,
    output logic                o_done,
    output logic [DATA_W-1:0]   o_mean,
    output logic [DATA_W-1:0]   o_min_val,
    output logic [DATA_W-1:0]   o_max_val,
`ifdef RNG_STATS_REPEAT_EN
    output logic [WIN_LOG2:0]   o_rep_cnt,
`endif
    output logic [WIN_LOG2:0]   o_sample_cnt
);

    localparam int SUM_W = DATA_W + WIN_LOG2;
    // Window length, one bit wider than the count of low bits so 2^WIN_LOG2 fits.
    localparam logic [WIN_LOG2:0] WIN_N    = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [WIN_LOG2:0] WIN_LAST = WIN_N - 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_run_min;
    logic [DATA_W-1:0] r_run_max;
    logic [WIN_LOG2:0] r_sample_cnt;
    logic [DATA_W-1:0] r_mean;
    logic [DATA_W-1:0] r_min_val;
    logic [DATA_W-1:0] r_max_val;

    logic              w_accept;
    logic              w_last;
    logic [SUM_W-1:0]  w_sum_next;
    logic [DATA_W-1:0] w_min_next;
    logic [DATA_W-1:0] w_max_next;
    logic [WIN_LOG2:0] w_cnt_next;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_ACC;
            S_ACC:   if (w_last)  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Both flags decode the state register only, so they carry no input path.
    assign o_busy = (r_state == S_ACC);
    assign o_done = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // Accumulator datapath
    // ------------------------------------------------------------------
    assign w_accept   = (r_state == S_ACC) && i_x_valid;
    assign w_last     = w_accept && (r_sample_cnt == WIN_LAST);
    assign w_sum_next = r_sum + {{WIN_LOG2{1'b0}}, i_x_in};
    assign w_min_next = (i_x_in < r_run_min) ? i_x_in : r_run_min;
    assign w_max_next = (i_x_in > r_run_max) ? i_x_in : r_run_max;
    // Saturate rather than wrap; the FSM leaves ACC at WIN_N anyway.
    assign w_cnt_next = (r_sample_cnt == WIN_N) ? r_sample_cnt : r_sample_cnt + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sum        <= '0;
            r_run_min    <= '1;
            r_run_max    <= '0;
            r_sample_cnt <= '0;
            r_mean       <= '0;
            r_min_val    <= '0;
            r_max_val    <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                // Any sample presented alongside start is deliberately dropped.
                r_sum        <= '0;
                r_run_min    <= '1;
                r_run_max    <= '0;
                r_sample_cnt <= '0;
            end else if (w_accept) begin
                r_sum        <= w_sum_next;
                r_run_min    <= w_min_next;
                r_run_max    <= w_max_next;
                r_sample_cnt <= w_cnt_next;
            end
            // Results are captured from the "next" values so the final sample
            // is included and the results are stable during the done cycle.
            if (w_last) begin
                r_mean    <= w_sum_next[SUM_W-1:WIN_LOG2];
                r_min_val <= w_min_next;
                r_max_val <= w_max_next;
            end
        end
    end

    assign o_mean       = r_mean;
    assign o_min_val    = r_min_val;
    assign o_max_val    = r_max_val;
    assign o_sample_cnt = r_sample_cnt;

`ifdef RNG_STATS_REPEAT_EN
    // ------------------------------------------------------------------
    // Repeat counter: a sample is a repeat when it equals the previous
    // accepted sample of the same window; a zero count marks the first.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_prev;
    logic [WIN_LOG2:0] r_rep;
    logic [WIN_LOG2:0] r_rep_cnt;
    logic [WIN_LOG2:0] w_rep_next;
    logic              w_is_rep;

    assign w_is_rep   = (r_sample_cnt != '0) && (i_x_in == r_prev);
    assign w_rep_next = w_is_rep ? r_rep + 1'b1 : r_rep;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev    <= '0;
            r_rep     <= '0;
            r_rep_cnt <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_rep <= '0;
            end else if (w_accept) begin
                r_prev <= i_x_in;
                r_rep  <= w_rep_next;
            end
            if (w_last) begin
                r_rep_cnt <= w_rep_next;
            end
        end
    end

    assign o_rep_cnt = r_rep_cnt;
`endif

endmodule

// File: doc/rng_window_stats.md
Name: rng_window_stats

Overview:
- Downstream consumer of the VT_RNG sample stream: takes the 18-bit x sample each clock and accumulates statistics over a window of 2^WIN_LOG2 valid samples.
- Statistics per window: sum-based mean, minimum, maximum.
- Used for on-chip health checks of the generator; results are read by the host/control logic after a done pulse.

Parameters:
- DATA_W, 18, sample width (matches VT_RNG x output).
- WIN_LOG2, 10, log2 of window length; legal range 1..20; window = 2^WIN_LOG2 samples.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new window; honoured only in IDLE.
- x_in  input  DATA_W  sample from VT_RNG x.
- x_valid  input  1  x_in carries a sample this cycle.
- busy  output  1  high in ACC state.
- done  output  1  one-cycle pulse when window results are valid.
- mean  output  DATA_W  floor(sum / 2^WIN_LOG2) of last completed window.
- min_val  output  DATA_W  smallest sample of last completed window.
- max_val  output  DATA_W  largest sample of last completed window.
- sample_cnt  output  WIN_LOG2+1  valid samples taken in current/last window.

Behaviour:
- Reset (sync, active-high, overrides everything): state=IDLE; busy=0, done=0, mean=0, min_val=0, max_val=0, sample_cnt=0; internal sum=0, run_min=all-ones, run_max=0.
- States: IDLE, ACC, DONE.
- IDLE: start=1 -> ACC next cycle; clear sum, sample_cnt; run_min=all-ones; run_max=0. A sample presented in the start cycle is NOT counted.
- ACC: busy=1. Each cycle with x_valid=1:
  - sum += x_in; sample_cnt += 1.
  - run_min = min(run_min, x_in); run_max = max(run_max, x_in) (unsigned compare).
- ACC: when the accepted sample makes sample_cnt reach 2^WIN_LOG2 -> DONE next cycle. That sample is included.
- ACC: x_valid=0 cycles hold all accumulators; no timeout.
- ACC: start ignored.
- DONE: lasts exactly 1 cycle; done=1; busy=0; -> IDLE.
  - mean, min_val, max_val are registered on the ACC->DONE transition, so they are stable while done=1 and held until the next window's DONE or reset.
  - x_valid ignored; start ignored.
- Latency: done asserts 1 cycle after the clock edge accepting the final sample.
- Arithmetic:
  - sum register width DATA_W+WIN_LOG2; cannot overflow.
  - mean = sum[DATA_W+WIN_LOG2-1 : WIN_LOG2] (truncation, no rounding).
  - sample_cnt saturates at 2^WIN_LOG2 (no wrap).
- Boundary cases:
  - Window of identical samples: min_val = max_val = mean = that value.
  - Sample 0x00000 or 0x3FFFF updates min/max correctly (init values allow it).
  - Reset mid-window: window discarded; results return to 0.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: RNG_STATS_REPEAT_EN.
- Defined:
  - Adds output rep_cnt (WIN_LOG2+1 bits): number of accepted samples in the window equal to the previously accepted sample of the same window. The first sample of a window is never a repeat.
  - Internal counter clears on start; rep_cnt is registered on ACC->DONE like the other results; reset value 0.
- Undefined: rep_cnt port and logic are absent; all other behaviour identical.

Test Plan (WIN_LOG2=2, window = 4 samples, unless noted):
- Reset, then idle 5 cycles -> busy=0, done=0, all result outputs 0, sample_cnt=0.
- start pulse, then x_valid=1 with samples 0x00010, 0x00020, 0x00030, 0x00041 -> done pulses 1 cycle after the 4th sample; mean=0x00028, min_val=0x00010, max_val=0x00041, sample_cnt=4.
- Same 4 samples with x_valid=0 gaps of 3 cycles between each, plus start re-pulsed during ACC -> identical results; done pulses once; start during ACC has no effect.
- Samples 0x3FFFF, 0x00000, 0x3FFFF, 0x00000 -> min_val=0x00000, max_val=0x3FFFF, mean=0x1FFFF (floor of 0x7FFFE/4). Sample in the start cycle = 0x12345 -> excluded from all results.
- Reset asserted after 2 samples of a window -> busy=0, results 0. New start + 4 samples of 0x00005 -> mean=min_val=max_val=0x00005.
- RNG_STATS_REPEAT_EN defined; samples 0x7, 0x7, 0x9, 0x7 -> rep_cnt=1. Then connect to VT_RNG (data=6995554, data2=8765), WIN_LOG2=10 -> results match the software model computed from golden.dat.
